memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
Parametrised successor to the single-word MEM pipeline stage of the MIPS core.
- Adds byte, halfword and word loads/stores with byte-lane write enables and sign/zero extension (LB/LBU/LH/LHU/LW/SB/SH/SW).
- Adds a configurable wait-state FSM that stalls the upstream pipeline for slower memories.
- Adds an asynchronous reset.
- Sits between the EX/MEM and MEM/WB pipeline registers; owns the data memory array.

Parameters:
ADDR_SIZE, 10, word-address bits; memory depth = 2**ADDR_SIZE 32-bit words (byte address uses ADDR_SIZE+2 bits)
WAIT_CYCLES, 0, extra cycles per load/store access; 0 = single-cycle, legal range 0..15

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
alu_data_ex_mem  input  32  ALU result; byte address for loads/stores
rt_data_ex_mem  input  32  store data, right-justified
mem_rd_ex_mem  input  1  load request
mem_wr_ex_mem  input  1  store request (mem_rd and mem_wr never both 1)
mem_size_ex_mem  input  2  0 byte, 1 half, 2 word, 3 reserved (treated as word)
mem_sign_ex_mem  input  1  1 = sign-extend load, 0 = zero-extend
rd_en_ex_mem  input  1  register write enable
rd_addr_ex_mem  input  5  destination register
rd_data_sel_ex_mem  input  1  1 = WB selects memory data
stall_mem  output  1  combinational; upstream holds EX/MEM inputs stable while 1
alu_data_mem_wb  output  32  registered ALU result
mem_data_mem_wb  output  32  registered, extended load data
rd_en_mem_wb  output  1  registered write enable
rd_addr_mem_wb  output  5  registered destination
rd_data_sel_mem_wb  output  1  registered select
misalign_mem_wb  output  1  registered misaligned-access flag

Behaviour:
- Reset (async, while rst=1):
  - All *_mem_wb outputs are 0.
  - FSM is IDLE, wait counter is 0, stall_mem is 0.
  - Array contents are not reset; they are zero-initialised at time 0 for simulation only.
- Addressing: word index = alu_data_ex_mem[ADDR_SIZE+1:2]; byte offset = alu_data_ex_mem[1:0]. Upper address bits are ignored, so accesses wrap modulo depth.
- Store lanes (little-endian):
  - Byte: lane = offset; data rt[7:0] replicated to all lanes.
  - Half: lanes {offset[1],0} and {offset[1],1}; data rt[15:0] replicated.
  - Word: all four lanes, rt[31:0].
  - Only the enabled lanes change.
- Load extract:
  - Byte: lane = offset. Half: halfword selected by offset[1]. Word: full word.
  - Result is sign-extended if mem_sign_ex_mem=1, otherwise zero-extended. mem_sign is ignored for word.
- Non-memory instructions (mem_rd=0, mem_wr=0): never stall; pass through in 1 cycle.
  - mem_data_mem_wb still captures the extracted value at the current address.
- FSM with WAIT_CYCLES=0: IDLE only. Every access completes in 1 cycle; the store commits at the clock edge that loads the MEM/WB registers.
- FSM with WAIT_CYCLES=N>0, states IDLE and WAIT:
  - Access presented in cycle t while in IDLE: stall_mem=1, go to WAIT, counter=N-1.
  - In WAIT with counter>0: stall_mem=1, counter decrements.
  - In WAIT with counter=0: stall_mem=0, return to IDLE. The store commits and the load samples at the end of this cycle (cycle t+N).
  - While stall_mem=1, MEM/WB captures a bubble: rd_en_mem_wb=0, misalign_mem_wb=0; other fields are don't-care.
  - Back-to-back accesses: the next access seen in IDLE at t+N+1 starts a new wait sequence; there is no idle gap beyond that.
  - Each store writes the array exactly once per instruction.
- Reset during WAIT: the access is aborted, no array write occurs, and the FSM is IDLE when rst deasserts.
- Read-during-write to the same word: the load returns the old contents (read-before-write).

Optional Feature:
Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - Misaligned means: half with offset[0]=1, or word with offset!=0.
  - A misaligned store writes nothing.
  - A misaligned load forces rd_en_mem_wb=0.
  - misalign_mem_wb=1 for that instruction's MEM/WB cycle.
  - Wait states still apply.
- Undefined:
  - No check; misalign_mem_wb is tied 0.
  - Half accesses ignore offset[0]; word accesses ignore offset[1:0] (access is aligned down).

Decomposition:
- Package mips_mem_pkg:
  - Size codes MEM_SIZE_BYTE=0, MEM_SIZE_HALF=1, MEM_SIZE_WORD=2.
  - Lane count 4.
  - Functions for lane-enable generation and load extraction/extension.
- One sub-module, mem_lane_ram:
  - Parameter ADDR_SIZE; synchronous write with 4 byte-enables; combinational read.
  - memory_stage instantiates it and owns the FSM, alignment check and pipeline registers.

Test Plan:
1. WAIT_CYCLES=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> mem_data_mem_wb=0xDEADBEEF one cycle later, stall_mem never 1.
2. SB 0x80 @0x13 over word 0x11223344, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80223344.
3. SH 0xABCD @0x22, then LH @0x22 -> 0xFFFFABCD; LHU -> 0x0000ABCD; LW @0x20 -> 0xABCD0000 (word previously 0).
4. WAIT_CYCLES=3: SW then LW, back-to-back.
   - stall_mem high exactly 3 cycles per access.
   - rd_en_mem_wb=0 during stalls.
   - Array written once.
   - LW returns the stored value.
5. rst asserted in the second WAIT cycle of a SW 0x12345678 @0x40 -> all outputs 0 immediately; later LW @0x40 -> old value 0.
6. MEM_ALIGN_CHECK_EN defined, SW @0x41 -> no write, misalign_mem_wb=1, rd_en_mem_wb=0. Undefined -> word @0x40 written, misalign_mem_wb=0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS memory stage: access-size codes,
// FSM states, byte-lane enable generation, store-data replication and
// load extraction with sign/zero extension.
package mips_mem_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2,
    MEM_SIZE_RSVD = 2'd3
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Little-endian lane enables; half ignores offset[0], word ignores offset.
  function automatic logic [LANES-1:0] lane_enables(input mem_size_e size,
                                                    input logic [1:0] offset);
    logic [LANES-1:0] en;
    case (size)
      MEM_SIZE_BYTE: en = 4'b0001 << offset;
      MEM_SIZE_HALF: en = offset[1] ? 4'b1100 : 4'b0011;
      default:       en = 4'b1111;
    endcase
    return en;
  endfunction

  // Replicate right-justified store data across every lane it may land in.
  function automatic logic [31:0] store_data(input mem_size_e size,
                                             input logic [31:0] rt);
    logic [31:0] d;
    case (size)
      MEM_SIZE_BYTE: d = {4{rt[7:0]}};
      MEM_SIZE_HALF: d = {2{rt[15:0]}};
      default:       d = rt;
    endcase
    return d;
  endfunction

  // Pick the addressed byte/half out of a word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input mem_size_e size,
                                               input logic [1:0] offset,
                                               input logic sign);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    logic [31:0]        r;
    b  = word[{offset, 3'b000} +: 8];
    h  = offset[1] ? word[31:16] : word[15:0];
    sx = '0;
    case (size)
      MEM_SIZE_BYTE: begin
        if (sign) begin
          sx = b;
          r  = sx;
        end else begin
          r = {24'd0, b};
        end
      end
      MEM_SIZE_HALF: begin
        if (sign) begin
          sx = h;
          r  = sx;
        end else begin
          r = {16'd0, h};
        end
      end
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_ram.sv
// Data memory array: 2**ADDR_SIZE 32-bit words, synchronous write with
// four byte-lane enables, combinational read (read-before-write on the
// same edge).
module mem_lane_ram
  import mips_mem_pkg::*;
#(
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic [LANES-1:0]     we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**ADDR_SIZE];

  // Update only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// MIPS MEM pipeline stage: byte/half/word loads and stores, optional
// wait-state FSM stalling the upstream pipeline, and the MEM/WB registers.
// Build option: define MEM_ALIGN_CHECK_EN to flag and suppress misaligned
// half/word accesses; otherwise such accesses are aligned down.
module memory_stage
  import mips_mem_pkg::*;
#(
  parameter int ADDR_SIZE   = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_data_ex_mem,
  input  logic [31:0] rt_data_ex_mem,
  input  logic        mem_rd_ex_mem,
  input  logic        mem_wr_ex_mem,
  input  logic [1:0]  mem_size_ex_mem,
  input  logic        mem_sign_ex_mem,
  input  logic        rd_en_ex_mem,
  input  logic [4:0]  rd_addr_ex_mem,
  input  logic        rd_data_sel_ex_mem,
  output logic        stall_mem,
  output logic [31:0] alu_data_mem_wb,
  output logic [31:0] mem_data_mem_wb,
  output logic        rd_en_mem_wb,
  output logic [4:0]  rd_addr_mem_wb,
  output logic        rd_data_sel_mem_wb,
  output logic        misalign_mem_wb
);

  localparam bit         HAS_WAIT = (WAIT_CYCLES != 0);
  localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [ADDR_SIZE-1:0] word_idx;
  logic [1:0]           offset;
  mem_size_e            size;
  logic                 access;
  logic                 misalign;
  logic                 stall;
  logic [LANES-1:0]     we;
  logic [31:0]          rdata;

  mem_state_e           state;
  logic [3:0]           cnt;

  logic [31:0]          alu_data_p0;
  logic [31:0]          mem_data_p0;
  logic                 rd_en_p0;
  logic [4:0]           rd_addr_p0;
  logic                 rd_data_sel_p0;
  logic                 misalign_p0;

  assign word_idx = alu_data_ex_mem[ADDR_SIZE+1:2];
  assign offset   = alu_data_ex_mem[1:0];
  assign size     = mem_size_e'(mem_size_ex_mem);
  assign access   = mem_rd_ex_mem | mem_wr_ex_mem;

`ifdef MEM_ALIGN_CHECK_EN
  // Half needs an even offset; word (and reserved, treated as word) needs offset 0.
  assign misalign = access &&
                    (((size == MEM_SIZE_HALF) && offset[0]) ||
                     ((size != MEM_SIZE_BYTE) && (size != MEM_SIZE_HALF) && (offset != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Stall while a new access starts in IDLE or the wait counter is still running.
  always_comb begin
    stall = 1'b0;
    if (!rst && HAS_WAIT) begin
      if (state == ST_IDLE) stall = access;
      else                  stall = (cnt != 4'd0);
    end
  end

  assign stall_mem = stall;

  // Commit a store only in the completing cycle; never during reset.
  assign we = (!rst && mem_wr_ex_mem && !stall && !misalign) ?
              lane_enables(size, offset) : '0;

  mem_lane_ram #(
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .addr  (word_idx),
    .wdata (store_data(size, rt_data_ex_mem)),
    .rdata (rdata)
  );

  // Wait-state sequencer: IDLE -> WAIT(N-1 .. 0) -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access && HAS_WAIT) begin
            state <= ST_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // MEM/WB register: bubble (no write-back, no misalign) while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_data_p0    <= '0;
      mem_data_p0    <= '0;
      rd_en_p0       <= 1'b0;
      rd_addr_p0     <= '0;
      rd_data_sel_p0 <= 1'b0;
      misalign_p0    <= 1'b0;
    end else begin
      alu_data_p0    <= alu_data_ex_mem;
      mem_data_p0    <= load_extract(rdata, size, offset, mem_sign_ex_mem);
      rd_en_p0       <= rd_en_ex_mem && !stall && !(misalign && mem_rd_ex_mem);
      rd_addr_p0     <= rd_addr_ex_mem;
      rd_data_sel_p0 <= rd_data_sel_ex_mem;
      misalign_p0    <= misalign && !stall;
    end
  end

  assign alu_data_mem_wb    = alu_data_p0;
  assign mem_data_mem_wb    = mem_data_p0;
  assign rd_en_mem_wb       = rd_en_p0;
  assign rd_addr_mem_wb     = rd_addr_p0;
  assign rd_data_sel_mem_wb = rd_data_sel_p0;
  assign misalign_mem_wb    = misalign_p0;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: one single-cycle instance (u_dut0) and one
// three-wait-state instance (u_dut3) sharing the same EX/MEM stimulus.
module tb_memory_stage;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_data, rt_data;
  logic        mem_rd, mem_wr, mem_sign, rd_en, rd_sel;
  logic [1:0]  mem_size;
  logic [4:0]  rd_addr;

  logic        stall0, rden0, sel0, mis0;
  logic [31:0] alu0, md0;
  logic [4:0]  rda0;
  logic        stall3, rden3, sel3, mis3;
  logic [31:0] alu3, md3;
  logic [4:0]  rda3;

  int n_tests = 0;
  int n_fail  = 0;
  int nst;

  always #5 clk = ~clk;

  memory_stage #(.ADDR_SIZE(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .alu_data_ex_mem(alu_data), .rt_data_ex_mem(rt_data),
    .mem_rd_ex_mem(mem_rd), .mem_wr_ex_mem(mem_wr),
    .mem_size_ex_mem(mem_size), .mem_sign_ex_mem(mem_sign),
    .rd_en_ex_mem(rd_en), .rd_addr_ex_mem(rd_addr), .rd_data_sel_ex_mem(rd_sel),
    .stall_mem(stall0), .alu_data_mem_wb(alu0), .mem_data_mem_wb(md0),
    .rd_en_mem_wb(rden0), .rd_addr_mem_wb(rda0), .rd_data_sel_mem_wb(sel0),
    .misalign_mem_wb(mis0)
  );

  memory_stage #(.ADDR_SIZE(10), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .alu_data_ex_mem(alu_data), .rt_data_ex_mem(rt_data),
    .mem_rd_ex_mem(mem_rd), .mem_wr_ex_mem(mem_wr),
    .mem_size_ex_mem(mem_size), .mem_sign_ex_mem(mem_sign),
    .rd_en_ex_mem(rd_en), .rd_addr_ex_mem(rd_addr), .rd_data_sel_ex_mem(rd_sel),
    .stall_mem(stall3), .alu_data_mem_wb(alu3), .mem_data_mem_wb(md3),
    .rd_en_mem_wb(rden3), .rd_addr_mem_wb(rda3), .rd_data_sel_mem_wb(sel3),
    .misalign_mem_wb(mis3)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] data,
                        input logic en, input logic [4:0] ra, input logic sel);
    mem_rd   = rd;
    mem_wr   = wr;
    mem_size = sz;
    mem_sign = sg;
    alu_data = addr;
    rt_data  = data;
    rd_en    = en;
    rd_addr  = ra;
    rd_sel   = sel;
  endtask

  task automatic idle_in();
    set_in(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  // One instruction through the single-cycle instance; outputs valid on return.
  task automatic do0(input logic rd, input logic wr, input logic [1:0] sz,
                     input logic sg, input logic [31:0] addr, input logic [31:0] data,
                     input logic en, input logic [4:0] ra, input logic sel);
    set_in(rd, wr, sz, sg, addr, data, en, ra, sel);
    #1;
    chk1("stall0_low", stall0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // One instruction through the wait-state instance; returns stall cycles seen.
  task automatic do3(input logic rd, input logic wr, input logic [1:0] sz,
                     input logic sg, input logic [31:0] addr, input logic [31:0] data,
                     input logic en, input logic [4:0] ra, input logic sel,
                     output int n);
    set_in(rd, wr, sz, sg, addr, data, en, ra, sel);
    n = 0;
    #1;
    while (stall3 && n < 20) begin
      n++;
      @(posedge clk);
      #1;
      chk1("bubble_rden3", rden3, 1'b0);
      chk1("bubble_mis3", mis3, 1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk32("rst_alu0", alu0, 32'h0);
    chk32("rst_md0", md0, 32'h0);
    chk1("rst_rden0", rden0, 1'b0);
    chk32("rst_rda0", {27'd0, rda0}, 32'h0);
    chk1("rst_sel0", sel0, 1'b0);
    chk1("rst_mis0", mis0, 1'b0);
    chk1("rst_stall0", stall0, 1'b0);
    chk1("rst_stall3", stall3, 1'b0);
    rst = 1'b0;

    // SW then LW, single cycle
    do0(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
    chk1("sw_rden", rden0, 1'b0);
    chk32("sw_alu", alu0, 32'h10);
    do0(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 5'd5, 1'b1);
    chk32("lw_data", md0, 32'hDEADBEEF);
    chk1("lw_rden", rden0, 1'b1);
    chk32("lw_rda", {27'd0, rda0}, 32'd5);
    chk1("lw_sel", sel0, 1'b1);

    // Byte store/load over 0x11223344
    do0(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0, 5'd0, 1'b0);
    do0(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, 1'b0, 5'd0, 1'b0);
    do0(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, 5'd1, 1'b1);
    chk32("lb_data", md0, 32'hFFFFFF80);
    do0(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1, 5'd1, 1'b1);
    chk32("lbu_data", md0, 32'h00000080);
    do0(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 5'd1, 1'b1);
    chk32("lw_after_sb", md0, 32'h80223344);

    // Store returns old word contents (read-before-write)
    do0(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h01020304, 1'b0, 5'd0, 1'b0);
    chk32("rbw_data", md0, 32'h80223344);

    // Halfword store/load into a cleared word
    do0(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 5'd0, 1'b0);
    do0(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h1234ABCD, 1'b0, 5'd0, 1'b0);
    do0(1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b1, 5'd2, 1'b1);
    chk32("lh_data", md0, 32'hFFFFABCD);
    do0(1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b1, 5'd2, 1'b1);
    chk32("lhu_data", md0, 32'h0000ABCD);
    do0(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 5'd2, 1'b1);
    chk32("lw_after_sh", md0, 32'hABCD0000);

    // Non-memory instruction passes through and still captures extracted data
    do0(1'b0, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b1, 5'd9, 1'b0);
    chk32("alu_md", md0, 32'h0000ABCD);
    chk1("alu_rden", rden0, 1'b1);
    chk32("alu_rda", {27'd0, rda0}, 32'd9);
    chk32("alu_alu", alu0, 32'h22);

    // Upper address bits ignored: 0x1020 wraps onto 0x20
    do0(1'b1, 1'b0, 2'd2, 1'b0, 32'h1020, 32'h0, 1'b1, 5'd2, 1'b1);
    chk32("wrap_data", md0, 32'hABCD0000);

    // Wait-state instance: resync FSM, then back-to-back SW/LW
    idle_in();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    do3(1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h0, 1'b0, 5'd0, 1'b0, nst);
    do3(1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, nst);
    chkn("sw3_stalls", nst, 3);
    chk32("sw3_alu", alu3, 32'h30);
    do3(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1, 5'd7, 1'b1, nst);
    chkn("lw3_stalls", nst, 3);
    chk32("lw3_data", md3, 32'hCAFEF00D);
    chk1("lw3_rden", rden3, 1'b1);
    chk32("lw3_rda", {27'd0, rda3}, 32'd7);
    do3(1'b0, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1, 5'd8, 1'b0, nst);
    chkn("alu3_stalls", nst, 0);
    chk1("alu3_rden", rden3, 1'b1);

    // Reset in the second WAIT cycle of a store aborts it
    do3(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0, 5'd0, 1'b0, nst);
    set_in(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, 1'b0, 5'd3, 1'b1);
    #1;
    chk1("abort_stall_t", stall3, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk1("abort_stall_w2", stall3, 1'b1);
    chk32("abort_pre_alu", alu3, 32'h40);
    rst = 1'b1;
    #1;
    chk32("abort_alu3", alu3, 32'h0);
    chk32("abort_rda3", {27'd0, rda3}, 32'h0);
    chk1("abort_sel3", sel3, 1'b0);
    chk1("abort_rden3", rden3, 1'b0);
    chk1("abort_mis3", mis3, 1'b0);
    chk32("abort_md3", md3, 32'h0);
    chk1("abort_stall3", stall3, 1'b0);
    idle_in();
    @(posedge clk);
    #1;
    rst = 1'b0;
    do3(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1, 5'd3, 1'b1, nst);
    chkn("abort_lw_stalls", nst, 3);
    chk32("abort_lw_data", md3, 32'h0);

    // Alignment check (or align-down when the check is not built in)
    do0(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0, 5'd0, 1'b0);
    do0(1'b0, 1'b1, 2'd2, 1'b0, 32'h41, 32'h55AA55AA, 1'b0, 5'd0, 1'b0);
    chk1("sw41_mis", mis0, ALIGN);
    chk1("sw41_rden", rden0, 1'b0);
    do0(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1, 5'd4, 1'b1);
    chk32("lw40_data", md0, ALIGN ? 32'h0 : 32'h55AA55AA);
    do0(1'b1, 1'b0, 2'd1, 1'b1, 32'h43, 32'h0, 1'b1, 5'd4, 1'b1);
    chk1("lh43_mis", mis0, ALIGN);
    chk1("lh43_rden", rden0, !ALIGN);
    if (!ALIGN) chk32("lh43_data", md0, 32'h000055AA);
    do3(1'b1, 1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 1'b1, 5'd6, 1'b1, nst);
    chkn("lw41_3_stalls", nst, 3);
    chk1("lw41_3_mis", mis3, ALIGN);
    chk1("lw41_3_rden", rden3, !ALIGN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
